// File: rtl/sqrt_bus_master_if.sv
// -----------------------------------------------------------------------------
// sqrt_bus_master_if
//   Groups the signals of the sqrt bus master:
//     - local control handshake: start/operand in, busy/valid/result/err out
//     - peripheral bus: cs/addr/rd/wr/d_out out, d_in back from the peripheral
//   Modports:
//     master : the sqrt_bus_master side (drives control status and the bus)
//     slave  : the environment side (control logic plus peripheral)
// -----------------------------------------------------------------------------
interface sqrt_bus_master_if;

    // control handshake
    logic        start;
    logic [15:0] operand;
    logic        busy;
    logic        valid;
    logic [15:0] result;
    logic        err;

    // peripheral bus
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [31:0] d_in;

    modport master (
        input  start, operand, d_in,
        output busy, valid, result, err,
        output cs, addr, rd, wr, d_out
    );

    modport slave (
        output start, operand, d_in,
        input  busy, valid, result, err,
        input  cs, addr, rd, wr, d_out
    );

endinterface

// File: rtl/sqrt_bus_master.sv
// -----------------------------------------------------------------------------
// sqrt_bus_master
//   Runs one square-root job on the memory-mapped sqrt peripheral:
//   write the operand, pulse init (1 then 0), wait MIN_WAIT cycles, poll the
//   done register, then read the result. If done is never seen within
//   MAX_POLLS polls the run ends with err=1 and result=0.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     bus    : sqrt_bus_master_if.master
//              start/operand  -> request (start only sampled in IDLE)
//              busy           <- high while a run is in flight
//              valid          <- one-cycle pulse qualifying result/err
//              result/err     <- held until overwritten by the next run
//              cs/addr/rd/wr/d_out -> peripheral bus, all registered
//              d_in           <- peripheral read data (bit 0 done, [15:0] root)
// -----------------------------------------------------------------------------
module sqrt_bus_master #(
    parameter logic [4:0]  ADDR_A    = 5'h04,
    parameter logic [4:0]  ADDR_INIT = 5'h08,
    parameter logic [4:0]  ADDR_RES  = 5'h0C,
    parameter logic [4:0]  ADDR_DONE = 5'h10,
    parameter int unsigned MIN_WAIT  = 4,     // 1..255
    parameter int unsigned MAX_POLLS = 1024   // 1..65535
) (
    input  logic               clk,
    input  logic               reset,
    sqrt_bus_master_if.master  bus
);

    localparam logic [7:0]  MIN_WAIT_C  = 8'(MIN_WAIT);
    localparam logic [15:0] MAX_POLLS_C = 16'(MAX_POLLS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_INIT_SET,
        S_WR_INIT_CLR,
        S_WAIT,
        S_RD_DONE_REQ,
        S_RD_DONE_SMP,
        S_RD_RES_REQ,
        S_RD_RES_SMP,
        S_FINISH
    } state_t;

    state_t      state_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;

    logic        busy_q;
    logic        valid_q;
    logic [15:0] result_q;
    logic        err_q;
    logic        cs_q;
    logic [4:0]  addr_q;
    logic        rd_q;
    logic        wr_q;
    logic [15:0] d_out_q;

    // Only the low half of the read data carries information.
    logic        unused_d_in_hi;
    assign unused_d_in_hi = ^bus.d_in[31:16];

    always_comb begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        poll_cnt_d = poll_cnt_q + 16'd1;
    end

    // Outputs are registered, so every transition loads the bus values of
    // the state being entered; anything not loaded falls back to bus idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            cs_q       <= 1'b0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            d_out_q    <= '0;
        end else begin
            cs_q    <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            d_out_q <= '0;
            valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        // operand is only needed for the first write, so
                        // d_out itself is the capture register
                        state_q <= S_WR_A;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= ADDR_A;
                        d_out_q <= bus.operand;
                    end
                end

                S_WR_A: begin
                    state_q <= S_WR_INIT_SET;
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                    addr_q  <= ADDR_INIT;
                    d_out_q <= 16'h0001;
                end

                S_WR_INIT_SET: begin
                    state_q <= S_WR_INIT_CLR;
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                    addr_q  <= ADDR_INIT;
                    d_out_q <= 16'h0000;
                end

                S_WR_INIT_CLR: begin
                    state_q    <= S_WAIT;
                    poll_cnt_q <= '0;
                    wait_cnt_q <= MIN_WAIT_C;
                end

                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_d;
                    // <= guards against a zero load if MIN_WAIT is misset
                    if (wait_cnt_q <= 8'd1) begin
                        state_q <= S_RD_DONE_REQ;
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= ADDR_DONE;
                    end
                end

                // Peripheral drives read data on the falling edge of the
                // request cycle; the sample cycle keeps the strobe up so the
                // data is stable at the edge that captures it.
                S_RD_DONE_REQ: begin
                    state_q <= S_RD_DONE_SMP;
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b1;
                    addr_q  <= ADDR_DONE;
                end

                S_RD_DONE_SMP: begin
                    if (bus.d_in[0]) begin
                        state_q <= S_RD_RES_REQ;
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= ADDR_RES;
                    end else begin
                        poll_cnt_q <= poll_cnt_d;
                        if (poll_cnt_d == MAX_POLLS_C) begin
                            state_q  <= S_FINISH;
                            err_q    <= 1'b1;
                            result_q <= '0;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD_DONE_REQ;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= ADDR_DONE;
                        end
                    end
                end

                S_RD_RES_REQ: begin
                    state_q <= S_RD_RES_SMP;
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b1;
                    addr_q  <= ADDR_RES;
                end

                S_RD_RES_SMP: begin
                    state_q  <= S_FINISH;
                    result_q <= bus.d_in[15:0];
                    err_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b1;
                end

                // valid is high during this cycle; start here is ignored
                S_FINISH: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.cs     = cs_q;
    assign bus.addr   = addr_q;
    assign bus.rd     = rd_q;
    assign bus.wr     = wr_q;
    assign bus.d_out  = d_out_q;

endmodule

// File: tb/tb_sqrt_bus_master.sv
// -----------------------------------------------------------------------------
// tb_sqrt_bus_master
//   Drives randomized and directed runs through sqrt_bus_master against a
//   behavioural sqrt peripheral whose done bit can be held low for a chosen
//   number of polls (or forever). Expected result, err, latency and bus
//   traffic come from plain arithmetic on the operand and done delay.
// -----------------------------------------------------------------------------
module tb_sqrt_bus_master;

    localparam int MW = 4;
    localparam int MP = 8;
    localparam logic [4:0] A_OP   = 5'h04;
    localparam logic [4:0] A_INIT = 5'h08;
    localparam logic [4:0] A_RES  = 5'h0C;
    localparam logic [4:0] A_DONE = 5'h10;
    localparam int NEVER = 100000;

    logic clk;
    logic reset;

    sqrt_bus_master_if bus_if();

    sqrt_bus_master #(.MIN_WAIT(MW), .MAX_POLLS(MP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // ---------------- behavioural peripheral + bus recorder ----------------
    int          peri_delay = 0;   // polls that read done=0 before done=1
    logic [15:0] peri_a     = '0;
    int          a_wr_cnt   = 0;
    logic [15:0] a_wr_val   = '0;
    logic [15:0] init_q[$];
    int          done_cyc   = 0;   // bus cycles with a done read
    int          res_cyc    = 0;   // bus cycles with a result read

    always @(posedge clk) begin
        if (!reset) begin
            if (bus_if.cs && bus_if.wr) begin
                if (bus_if.addr == A_OP) begin
                    peri_a   = bus_if.d_out;
                    a_wr_val = bus_if.d_out;
                    a_wr_cnt++;
                end else if (bus_if.addr == A_INIT) begin
                    init_q.push_back(bus_if.d_out);
                    if (bus_if.d_out == 16'h0) done_cyc = 0;
                end
            end
            if (bus_if.cs && bus_if.rd && bus_if.addr == A_DONE) done_cyc++;
            if (bus_if.cs && bus_if.rd && bus_if.addr == A_RES)  res_cyc++;
        end
    end

    // Read data changes on the falling edge; upper bits carry junk.
    always @(negedge clk) begin
        logic [31:0] r;
        r = $urandom;
        if (bus_if.cs && bus_if.rd && bus_if.addr == A_DONE)
            bus_if.d_in = {r[31:1], ((done_cyc / 2) >= peri_delay)};
        else if (bus_if.cs && bus_if.rd && bus_if.addr == A_RES)
            bus_if.d_in = {r[31:16], 16'(isqrt(int'(peri_a)))};
        else
            bus_if.d_in = r;
    end

    // Bus invariants every cycle out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_exclusive", 32'(bus_if.rd & bus_if.wr), 0);
            chk("cs_covers_strobe", 32'((bus_if.rd | bus_if.wr) & ~bus_if.cs), 0);
            chk("valid_not_busy", 32'(bus_if.valid & bus_if.busy), 0);
        end
    end

    task automatic chk_reset_vals(input string ctx);
        chk({ctx, "_busy"},   32'(bus_if.busy),   0);
        chk({ctx, "_valid"},  32'(bus_if.valid),  0);
        chk({ctx, "_result"}, 32'(bus_if.result), 0);
        chk({ctx, "_err"},    32'(bus_if.err),    0);
        chk({ctx, "_cs"},     32'(bus_if.cs),     0);
        chk({ctx, "_addr"},   32'(bus_if.addr),   0);
        chk({ctx, "_rd"},     32'(bus_if.rd),     0);
        chk({ctx, "_wr"},     32'(bus_if.wr),     0);
        chk({ctx, "_d_out"},  32'(bus_if.d_out),  0);
    endtask

    // One run: start at cycle 0, expect valid at the modelled latency.
    // keep_start leaves start high through the valid cycle (spam mode) and
    // returns straight away so the next run can start the following cycle.
    task automatic do_run(input logic [15:0] x, input int dly, input bit spam);
        int  exp_lat, exp_pairs, vcyc;
        bit  timeout;
        logic [15:0] exp_res;
        timeout   = (dly >= MP);
        exp_lat   = timeout ? (3 + MW + 2 * MP + 1) : (MW + 8 + 2 * dly);
        exp_pairs = timeout ? MP : dly + 1;
        exp_res   = timeout ? 16'd0 : 16'(isqrt(int'(x)));

        @(negedge clk);
        chk("idle_before_start", 32'(bus_if.valid | bus_if.busy), 0);
        a_wr_cnt = 0; init_q.delete(); done_cyc = 0; res_cyc = 0;
        peri_delay = dly;
        bus_if.start   = 1'b1;
        bus_if.operand = x;

        vcyc = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus_if.valid) begin
                vcyc = n;
                chk("busy_low_at_valid", 32'(bus_if.busy), 0);
                break;
            end
            chk("busy_during_run", 32'(bus_if.busy), 1);
            if (spam) begin
                bus_if.start   = 1'b1;
                bus_if.operand = 16'($urandom);
            end else begin
                bus_if.start = 1'b0;
            end
        end
        chk("valid_seen", 32'(vcyc > 0), 1);
        chk("latency", 32'(vcyc), 32'(exp_lat));
        chk("result", 32'(bus_if.result), 32'(exp_res));
        chk("err", 32'(bus_if.err), 32'(timeout));
        chk("op_writes", 32'(a_wr_cnt), 1);
        chk("op_value", 32'(a_wr_val), 32'(x));
        chk("init_writes", 32'(init_q.size()), 2);
        if (init_q.size() == 2) begin
            chk("init_set", 32'(init_q[0]), 1);
            chk("init_clr", 32'(init_q[1]), 0);
        end
        chk("done_read_cycles", 32'(done_cyc), 32'(2 * exp_pairs));
        chk("res_read_cycles", 32'(res_cyc), timeout ? 0 : 2);

        if (!spam) begin
            repeat (2) begin
                @(negedge clk);
                chk("post_valid", 32'(bus_if.valid), 0);
                chk("post_busy", 32'(bus_if.busy), 0);
                chk("post_bus_idle", 32'({bus_if.cs, bus_if.rd, bus_if.wr, bus_if.addr, bus_if.d_out}), 0);
                chk("post_result_held", 32'(bus_if.result), 32'(exp_res));
                chk("post_err_held", 32'(bus_if.err), 32'(timeout));
            end
        end
    endtask

    // Start a run, then assert reset at the end of cycle at_cycle.
    task automatic reset_mid_run(input int dly, input int at_cycle, input bit in_smp);
        @(negedge clk);
        peri_delay     = dly;
        bus_if.start   = 1'b1;
        bus_if.operand = 16'd500;
        for (int n = 1; n <= at_cycle; n++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
        end
        chk("pre_reset_busy", 32'(bus_if.busy), 1);
        chk("pre_reset_rd", 32'(bus_if.rd), 32'(in_smp));
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.operand = '0;
        bus_if.d_in    = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        do_run(16'd144,   0, 1'b0);
        do_run(16'd0,     0, 1'b0);
        do_run(16'd65535, 0, 1'b0);
        do_run(16'd2,     0, 1'b0);
        do_run(16'd400,   3, 1'b0);     // done after 3 zero polls -> cycle 18
        do_run(16'd1234,  NEVER, 1'b0); // stuck done -> timeout
        do_run(16'd1000,  MP - 1, 1'b0);
        do_run(16'd1001,  MP, 1'b0);

        do_run(16'd900, 1, 1'b1);       // start spammed during the run
        do_run(16'd49,  0, 1'b0);       // accepted the cycle after valid

        for (int i = 0; i < 16; i++)
            do_run(16'($urandom), int'($urandom_range(0, MP + 1)), 1'($urandom_range(0, 1)));
        do_run(16'd10, 0, 1'b0);

        do_run(16'd144, 0, 1'b0);
        reset_mid_run(0, 5, 1'b0);      // WAIT
        do_run(16'd81, 0, 1'b0);
        reset_mid_run(2, MW + 5, 1'b1); // first RD_DONE_SMP
        do_run(16'd81, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_bus_master.md
Name: sqrt_bus_master

Overview:
- Bus initiator that drives one square-root run on the memory-mapped sqrt peripheral: write operand, pulse init, poll done, read result.
- Sits between local control logic (simple start/valid handshake) and the peripheral's cs/addr/rd/wr/data bus.
- Relieves the CPU of polling and exposes a timeout error if the peripheral never reports done.

Parameters:
- ADDR_A, 5'h04, peripheral operand register address
- ADDR_INIT, 5'h08, peripheral init register address
- ADDR_RES, 5'h0C, peripheral result register address
- ADDR_DONE, 5'h10, peripheral done register address
- MIN_WAIT, 4, cycles between init clear and first done poll (1..255)
- MAX_POLLS, 1024, done polls before timeout error (1..65535)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- operand  in  16  radicand; captured on accepted start
- busy  out  1  high from the cycle after accepted start until return to IDLE
- valid  out  1  one-cycle pulse: result/err valid
- result  out  16  square root; held until next accepted start
- err  out  1  timeout flag; qualified by valid, held like result
- cs  out  1  peripheral chip select
- addr  out  5  peripheral register address
- rd  out  1  read strobe
- wr  out  1  write strobe
- d_out  out  16  write data to peripheral d_in
- d_in  in  32  read data from peripheral d_out

Behaviour:
- Reset values: busy=0, valid=0, result=0, err=0, cs=0, addr=0, rd=0, wr=0, d_out=0. FSM goes to IDLE and counters clear. Reset has priority in any state.
- All bus outputs are registered, and each state's bus values appear during that state's cycle. Outside bus states: cs=rd=wr=0, addr=0, d_out=0.
- IDLE: if start=1, capture operand and go to WR_A. Otherwise stay.
- WR_A, 1 cycle: cs=1, wr=1, addr=ADDR_A, d_out=operand. Go to WR_INIT_SET.
- WR_INIT_SET, 1 cycle: cs=1, wr=1, addr=ADDR_INIT, d_out=16'h0001. Go to WR_INIT_CLR.
- WR_INIT_CLR, 1 cycle: cs=1, wr=1, addr=ADDR_INIT, d_out=0. Clear the poll counter, load the wait counter with MIN_WAIT, go to WAIT.
- WAIT: bus idle; decrement the wait counter. At 1, go to RD_DONE_REQ.
- RD_DONE_REQ, 1 cycle: cs=1, rd=1, addr=ADDR_DONE. The peripheral updates its read data on the falling edge. Go to RD_DONE_SMP.
- RD_DONE_SMP, 1 cycle: same cs/rd/addr held. Sample d_in[0] at the end of this cycle.
  - If d_in[0]=1: go to RD_RES_REQ.
  - Else increment the poll counter. If the counter reaches MAX_POLLS, set err=1, result=0 and go to FINISH. Otherwise go to RD_DONE_REQ.
  - d_in[31:1] is ignored.
- RD_RES_REQ / RD_RES_SMP: same two-cycle read pattern at ADDR_RES. Capture d_in[15:0] into result at the end of RD_RES_SMP, set err=0, go to FINISH. d_in[31:16] is ignored.
- FINISH, 1 cycle: valid=1, bus idle. Go to IDLE. busy drops in the same cycle that valid pulses.
- start while busy=1 is ignored with no queueing. start in the cycle valid pulses is also ignored; the earliest accepted start is the cycle after valid.
- Latency with done seen on the first poll: start accepted at cycle 0, valid at cycle 3+MIN_WAIT+2+2+1 = MIN_WAIT+8.
- Each extra poll adds 2 cycles.
- Timeout valid arrives 3+MIN_WAIT+2*MAX_POLLS+1 cycles after start.
- wr and rd are never high together. cs is high whenever wr or rd is high.

Test Plan:
- Reset, then start with operand=144 against the real peripheral: bus trace shows A=144, init 1 then 0, done polls, result read; valid pulses once with result=12, err=0.
- operand=0 → result=0. operand=65535 → result=255. operand=2 → result=1 (floor). Each run has exactly one valid pulse.
- Behavioural peripheral that holds done=0 for 3 polls (MIN_WAIT=4) → valid at cycle 18 after start, with 4 RD_DONE read pairs on the bus.
- Peripheral with done stuck at 0, MAX_POLLS=8 → valid with err=1, result=0, exactly 8 poll pairs, then IDLE with the bus idle.
- start pulses every cycle during a run → only the first is accepted: one operand write and one valid. The next start, in the cycle after valid, is accepted with the new operand.
- reset asserted during WAIT and again during RD_DONE_SMP → next cycle all outputs are at reset values and FSM is in IDLE. A following start=1 with operand=81 yields result=9.
